// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC sequencer: next-PC mode encoding and FSM states.
package pc_pkg;

    localparam int unsigned PC_SEL_W = 3;

    // Next-PC mode; codes 6 and 7 are unassigned and fall back to sequential flow.
    typedef enum logic [PC_SEL_W-1:0] {
        PC_SEQ   = 3'd0,
        PC_BR_I  = 3'd1,
        PC_JMP_D = 3'd2,
        PC_REG_I = 3'd3,
        PC_SIIC  = 3'd4,
        PC_RTI   = 3'd5
    } pc_sel_t;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational non-exception next-PC target: base/offset selection, sign extension and adder.
// Exception entry and RTI are resolved by the sequencer; here they fall back to pc+ILEN.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned IW   = 8,
    parameter int unsigned DW   = 11,
    parameter int unsigned ILEN = 2
) (
    input  logic [W-1:0]        pc,
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic                br_taken,
    input  logic [IW-1:0]       imm_i,
    input  logic [DW-1:0]       imm_d,
    input  logic [W-1:0]        rs_val,
    output logic [W-1:0]        pc_plus,
    output logic [W-1:0]        target
);

    localparam logic [W-1:0] ILEN_W = W'(ILEN);

    logic [W-1:0] imm_i_ext_s;
    logic [W-1:0] imm_d_ext_s;
    logic [W-1:0] base_s;
    logic [W-1:0] offset_s;

    assign imm_i_ext_s = {{(W-IW){imm_i[IW-1]}}, imm_i};
    assign imm_d_ext_s = {{(W-DW){imm_d[DW-1]}}, imm_d};
    assign pc_plus     = pc + ILEN_W;

    // Select adder base and offset for the requested flow; wrap-around is intentional.
    always_comb begin
        base_s   = pc_plus;
        offset_s = {W{1'b0}};
        case (pc_sel)
            PC_BR_I: begin
                if (br_taken) begin
                    offset_s = imm_i_ext_s;
                end else begin
                    offset_s = {W{1'b0}};
                end
            end
            PC_JMP_D: offset_s = imm_d_ext_s;
            PC_REG_I: begin
                base_s   = rs_val;
                offset_s = imm_i_ext_s;
            end
            default: begin
                base_s   = pc_plus;
                offset_s = {W{1'b0}};
            end
        endcase
    end

    assign target = base_s + offset_s;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns PC and EPC, runs the RUN/FLUSH/HALT FSM,
// handles exception entry/return and flags nested exceptions as a sticky error.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned IW         = 8,
    parameter int unsigned DW         = 11,
    parameter int unsigned ILEN       = 2,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned EXC_VECTOR = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic                br_taken,
    input  logic [IW-1:0]       imm_i,
    input  logic [DW-1:0]       imm_d,
    input  logic [W-1:0]        rs_val,
    input  logic                halt,
    output logic [W-1:0]        pc,
    output logic [W-1:0]        pc_plus,
    output logic [W-1:0]        epc,
    output logic                fetch_valid,
    output logic                in_handler,
    output logic                halted,
    output logic                err
);

    localparam logic [W-1:0] RESET_PC_W   = W'(RESET_PC);
    localparam logic [W-1:0] EXC_VECTOR_W = W'(EXC_VECTOR);

    pc_state_t    state_r;
    logic [W-1:0] pc_r;
    logic [W-1:0] epc_r;
    logic         in_handler_r;
    logic         err_r;
    logic [W-1:0] pc_plus_s;
    logic [W-1:0] target_s;

    pc_target_calc #(
        .W    (W),
        .IW   (IW),
        .DW   (DW),
        .ILEN (ILEN)
    ) u_target (
        .pc       (pc_r),
        .pc_sel   (pc_sel),
        .br_taken (br_taken),
        .imm_i    (imm_i),
        .imm_d    (imm_d),
        .rs_val   (rs_val),
        .pc_plus  (pc_plus_s),
        .target   (target_s)
    );

    // Sequencer FSM: stall > halt > pc_sel in RUN; FLUSH is a single dead fetch slot; HALT is terminal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RUN;
            pc_r         <= RESET_PC_W;
            epc_r        <= {W{1'b0}};
            in_handler_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (stall) begin
                        state_r <= RUN;
                    end else if (halt) begin
                        state_r <= HALT;
                    end else begin
                        case (pc_sel)
                            PC_SIIC: begin
                                if (in_handler_r) begin
                                    err_r   <= 1'b1;
                                    state_r <= HALT;
                                end else begin
                                    epc_r        <= pc_plus_s;
                                    pc_r         <= EXC_VECTOR_W;
                                    in_handler_r <= 1'b1;
                                    state_r      <= FLUSH;
                                end
                            end
                            PC_RTI: begin
                                pc_r         <= epc_r;
                                in_handler_r <= 1'b0;
                            end
                            default: pc_r <= target_s;
                        endcase
                    end
                end
                FLUSH:   state_r <= RUN;
                HALT:    state_r <= HALT;
                default: state_r <= HALT;
            endcase
        end
    end

    assign pc          = pc_r;
    assign pc_plus     = pc_plus_s;
    assign epc         = epc_r;
    assign in_handler  = in_handler_r;
    assign err         = err_r;
    assign fetch_valid = (state_r == RUN);
    assign halted      = (state_r == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected post-edge state,
// a negedge monitor pops and compares.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  pc_sel;
    logic        br_taken;
    logic [7:0]  imm_i;
    logic [10:0] imm_d;
    logic [15:0] rs_val;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic [15:0] epc;
    logic        fetch_valid;
    logic        in_handler;
    logic        halted;
    logic        err;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] epc;
        logic        fv;
        logic        ih;
        logic        hl;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .br_taken    (br_taken),
        .imm_i       (imm_i),
        .imm_d       (imm_d),
        .rs_val      (rs_val),
        .halt        (halt),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .epc         (epc),
        .fetch_valid (fetch_valid),
        .in_handler  (in_handler),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT state against the oldest expectation once per cycle.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus", pc_plus, e.pc + 16'd2);
            chk("epc", epc, e.epc);
            chk("fetch_valid", {15'd0, fetch_valid}, {15'd0, e.fv});
            chk("in_handler", {15'd0, in_handler}, {15'd0, e.ih});
            chk("halted", {15'd0, halted}, {15'd0, e.hl});
            chk("err", {15'd0, err}, {15'd0, e.er});
        end
    end

    task automatic step(input logic [2:0] sel, input logic br, input logic [7:0] ii,
                        input logic [10:0] id, input logic [15:0] rs, input logic st,
                        input logic hl_in, input logic [15:0] e_pc, input logic [15:0] e_epc,
                        input logic e_fv, input logic e_ih, input logic e_hl, input logic e_er);
        exp_t e;
        @(negedge clk);
        #1;
        pc_sel   = sel;
        br_taken = br;
        imm_i    = ii;
        imm_d    = id;
        rs_val   = rs;
        stall    = st;
        halt     = hl_in;
        e.pc = e_pc; e.epc = e_epc; e.fv = e_fv; e.ih = e_ih; e.hl = e_hl; e.er = e_er;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset between clock edges; inputs parked with stall so release causes no move.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        stall  = 1'b1;
        halt   = 1'b0;
        pc_sel = 3'd0;
        rst_n  = 1'b0;
        #1;
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_epc"}, epc, 16'h0000);
        chk({tag, "_fetch_valid"}, {15'd0, fetch_valid}, 16'h0001);
        chk({tag, "_err"}, {15'd0, err}, 16'h0000);
        chk({tag, "_halted"}, {15'd0, halted}, 16'h0000);
        chk({tag, "_in_handler"}, {15'd0, in_handler}, 16'h0000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; stall = 1'b1; pc_sel = 3'd0; br_taken = 1'b0;
        imm_i = 8'h00; imm_d = 11'h000; rs_val = 16'h0000; halt = 1'b0;
        do_reset("rst0");

        //   sel   br    imm_i  imm_d    rs_val    st    halt  pc        epc       fv    ih    hl    err
        step(3'd0, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'h0010, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd1, 1'b1, 8'hFC, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h000E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'h0010, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd1, 1'b0, 8'hFC, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 11'h004, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 11'h7FC, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd3, 1'b0, 8'h80, 11'h000, 16'h1000, 1'b0, 1'b0, 16'h0F80, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd6, 1'b1, 8'h10, 11'h010, 16'h0000, 1'b0, 1'b0, 16'h0F82, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd7, 1'b1, 8'h10, 11'h010, 16'h0000, 1'b0, 1'b0, 16'h0F84, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'h0040, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // stall beats halt and SIIC
        step(3'd4, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // exception entry, then FLUSH ignores stall/halt/SIIC
        step(3'd4, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);
        step(3'd0, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);
        step(3'd5, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd0, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0044, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
        // RTI outside a handler still loads epc without error
        step(3'd5, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
        // halt beats pc_sel; HALT is terminal
        step(3'd2, 1'b0, 8'h00, 11'h010, 16'h0000, 1'b0, 1'b1, 16'h0042, 16'h0042, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'h1234, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset("rst_halt");

        // nested exception
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'h0040, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'd0, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b1);
        step(3'd0, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b1);
        step(3'd5, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b1);
        do_reset("rst_err");

        // reset while in FLUSH
        step(3'd3, 1'b0, 8'h00, 11'h000, 16'h0040, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset("rst_flush");
        step(3'd0, 1'b0, 8'h00, 11'h000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        chk("scoreboard_drain", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch-stage program-counter sequencer: owns the architectural PC register, computes the next PC for sequential, branch, jump, register-jump, exception-entry (SIIC) and return-from-exception (RTI) flow, and holds the EPC. Sits between decode/execute control (which supplies the select, offsets and Rs) and instruction memory (which consumes `pc` and `fetch_valid`). Adds the state the earlier combinational next-PC adder lacked: PC/EPC registers, stall, a one-cycle exception flush, nested-exception detection and halt.

## Interface
- `W`, 16: PC/datapath width.
- `IW`, 8: width of the short (branch/register) immediate.
- `DW`, 11: width of the long (jump) displacement.
- `ILEN`, 2: instruction length in bytes.
- `RESET_PC`, 0: PC after reset.
- `EXC_VECTOR`, 2: exception handler address.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold PC; all requests ignored this cycle.
- `pc_sel`  in  3  next-PC mode (package enum).
- `br_taken`  in  1  qualifies `PC_BR_I`.
- `imm_i`  in  IW  short immediate, sign-extended.
- `imm_d`  in  DW  long displacement, sign-extended.
- `rs_val`  in  W  register base for `PC_REG_I`.
- `halt`  in  1  HALT instruction retired.
- `pc`  out  W  current fetch PC.
- `pc_plus`  out  W  `pc + ILEN` (combinational, for link writes).
- `epc`  out  W  saved return PC.
- `fetch_valid`  out  1  fetch slot valid.
- `in_handler`  out  1  exception handler active.
- `halted`  out  1  sequencer halted.
- `err`  out  1  sticky nested-exception error.

## Operation
- Modes: `PC_SEQ` -> `pc+ILEN`; `PC_BR_I` -> `pc+ILEN+sext(imm_i)` if `br_taken`, else `pc+ILEN`; `PC_JMP_D` -> `pc+ILEN+sext(imm_d)`; `PC_REG_I` -> `rs_val+sext(imm_i)`; `PC_SIIC` -> exception entry; `PC_RTI` -> `epc`. Codes 6-7 behave as `PC_SEQ`.
- All arithmetic modulo 2^W; wrap-around silent, no overflow flag.
- FSM states `RUN`, `FLUSH`, `HALT`.
- `RUN`: if `stall`, nothing changes. Else if `halt`: state -> `HALT`, PC holds. Else apply mode.
- SIIC in `RUN`, `!in_handler`: `epc <= pc+ILEN`, `pc <= EXC_VECTOR`, `in_handler <= 1`, state -> `FLUSH`.
- SIIC in `RUN` with `in_handler=1`: `err <= 1`, state -> `HALT`, PC and EPC hold.
- RTI: `pc <= epc`, `in_handler <= 0`; RTI with `in_handler=0` still loads `epc`, no error.
- `FLUSH`: one cycle, `fetch_valid=0`, PC holds, all inputs ignored (including `stall`); -> `RUN`.
- `HALT`: terminal until reset; PC, EPC, flags hold, `fetch_valid=0`, `halted=1`.
- Priority in `RUN`: `stall` > `halt` > `pc_sel`.

## Timing
- Reset (async assert, sync deassert by caller): `pc=RESET_PC`, `epc=0`, `in_handler=0`, `err=0`, state `RUN`, `fetch_valid=1`, `halted=0`.
- Registered outputs update on rising `clk`; `pc_plus`, `fetch_valid`, `halted` combinational from state/PC.
- Redirect latency 1 cycle: mode applied in cycle N visible on `pc` in N+1.
- SIIC: vector on `pc` at N+1, `fetch_valid=0` at N+1, first handler fetch valid at N+2.
- Reset mid-`FLUSH` or `HALT` returns to reset state immediately.

## Structure
- Package `pc_pkg`: `pc_sel_t` enum (`PC_SEQ=0, PC_BR_I=1, PC_JMP_D=2, PC_REG_I=3, PC_SIIC=4, PC_RTI=5`), `pc_state_t` (`RUN, FLUSH, HALT`).
- One sub-module: `pc_target_calc` — combinational base/offset mux, sign extension and adder producing the non-exception target; sequencer holds registers and FSM.

## Test plan
- Reset: `rst_n=0` mid-run -> `pc=0, epc=0, fetch_valid=1, err=0` asynchronously.
- Branch: `pc=0x0010`, `PC_BR_I`, `imm_i=0xFC`, taken -> `pc=0x000E`; not taken -> `0x0012`.
- Jump/reg/wrap: `pc=0xFFFE`, `PC_JMP_D`, `imm_d=0x004` -> `0x0004`; `PC_REG_I`, `rs_val=0x1000`, `imm_i=0x80` -> `0x0F80`.
- Exception round trip: `pc=0x0040`, `PC_SIIC` -> `pc=0x0002, epc=0x0042, fetch_valid=0` one cycle; later `PC_RTI` -> `pc=0x0042, in_handler=0`.
- Nested SIIC inside handler -> `err=1, halted=1`, PC frozen until reset.
- `stall=1` with `PC_SIIC` and `halt` -> no change; on release `PC_SIIC` alone -> entry as above.
